hwdbg_trace_capture: RTL and testbench
======================================

// Module: hwdbg_trace_capture
// PURPOSE
//  Logic-analyser trace buffer on the Microwatt external-IO Wishbone port (wb_ext_io), downstream of the SoC core.
//  Samples a 32-bit probe bus into a circular RAM; stops after a programmable post-trigger count.
//  CPU (or JTAG debugger via CPU) arms, polls and drains the buffer through 8 word registers; level IRQ on completion.
// PARAMETERS
//  DEPTH_LOG2  8      log2 of buffer entries (256 x 32 bit)
//  RESET_MASK  32'h0  reset value of TRIG_MASK
// PORTS
//  ext_clk     in   1   sole clock
//  ext_rst_n   in   1   asynchronous, active-low reset
//  wb_adr_i    in   30  word address; only [2:0] decoded (window select done upstream)
//  wb_dat_i    in   32  write data
//  wb_sel_i    in   4   byte enables
//  wb_cyc_i    in   1   cycle
//  wb_stb_i    in   1   strobe
//  wb_we_i     in   1   write enable
//  wb_dat_o    out  32  read data, valid with wb_ack_o
//  wb_ack_o    out  1   one-cycle acknowledge
//  wb_stall_o  out  1   pipelined stall, constant 0
//  probe_i     in   32  traced signal bus
//  probe_vld_i in   1   sample-enable qualifier
//  irq_done_o  out  1   level IRQ: state==DONE && CTRL.IRQ_EN
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, irq_done_o=0, state=IDLE, pointers/counters 0, TRIG_MASK=RESET_MASK, others 0.
//  Bus: request accepted when cyc&stb; ack exactly 1 cycle later, back-to-back accepted every cycle; no errors.
//  Registers (adr[2:0]): 0 CTRL W:[0]ARM [1]ABORT [2]FORCE, RW:[3]IRQ_EN; 1 STATUS R:[1:0]state [2]wrapped [31:16]fill;
//   2 TRIG_VAL RW; 3 TRIG_MASK RW; 4 POST_CNT RW[DEPTH_LOG2-1:0]; 5 DATA R(pop); 6/7 see CONFIGURATION.
//  RW writes honour wb_sel_i per byte; CTRL command bits act only when sel[0]=1; writes to R-only offsets ignored.
//  FSM IDLE(0) -ARM-> ARMED(1) -trigger-> TRIGGERED(2) -post done-> DONE(3); ARM valid from IDLE/DONE only.
//  ARM clears wr_ptr, rd_ptr, fill, post counter, wrapped; takes effect next cycle. ABORT -> IDLE from any state.
//  ABORT and ARM in same write: ABORT wins. FORCE in ARMED = trigger on next cycle regardless of probe.
//  ARMED/TRIGGERED: each probe_vld_i cycle writes probe_i to buf[wr_ptr], wr_ptr++ mod 2^DEPTH_LOG2, fill saturates at DEPTH.
//  wrapped sets when wr_ptr wraps. Trigger: ARMED && probe_vld_i && (probe_i & MASK)==(TRIG_VAL & MASK); trigger sample is stored.
//  TRIGGERED: DONE after POST_CNT further stored samples; POST_CNT=0 -> DONE the cycle after trigger sample.
//  DONE: no writes; rd_ptr starts at 0 if !wrapped else at wr_ptr (oldest sample first).
//  DATA read in DONE with samples left: returns buf[rd_ptr] (sync RAM, data ready at ack), rd_ptr++; returns 0 and no move otherwise.
//  Reset mid-capture: immediate return to reset state; RAM contents undefined, never read before next DONE.
// CONFIGURATION
//  HWDBG_TRACE_TSTAMP_EN defined: offset 6 = free-running 32-bit cycle counter (wraps, reset 0), offset 7 = counter value latched at trigger.
//  Not defined: offsets 6/7 read 0, counter logic absent.
// STRUCTURE
//  Package hwdbg_trace_pkg: FSM state encoding, register offsets, CTRL/STATUS bit positions.
//  Sub-module hwdbg_trace_ram: 1W1R synchronous RAM, 2^DEPTH_LOG2 x 32, registered read.
// TESTING
//  Reset then read all 8 offsets -> 0 except TRIG_MASK=RESET_MASK; ack 1 cycle after each stb.
//  MASK=FFFF_FFFF, VAL=0x55, POST=3, ARM, probe counts 0x50.. -> DONE after 0x58; fill=9; DATA pops 0x50..0x58, 10th pop 0.
//  DEPTH_LOG2=4, VAL unmatched for 40 samples then FORCE, POST=2 -> wrapped=1, fill=16, first pop = oldest (sample 27).
//  ARM|ABORT in one write -> state stays IDLE; ABORT during TRIGGERED -> IDLE, irq_done_o 0.
//  IRQ_EN=1 at DONE -> irq_done_o=1; re-ARM clears it next cycle; reset asserted mid-TRIGGERED -> all outputs 0 async.
//  With HWDBG_TRACE_TSTAMP_EN: trigger at cycle N after reset -> offset 7 reads N; without macro offsets 6/7 read 0.

Source files
------------

// File: rtl/hwdbg_trace_pkg.sv
// Shared definitions for the hwdbg trace capture block: FSM state encoding,
// Wishbone register offsets, CTRL/STATUS bit positions and a byte-merge helper.
package hwdbg_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } trace_state_e;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_TRIG_VAL  = 3'd2;
    localparam logic [2:0] REG_TRIG_MASK = 3'd3;
    localparam logic [2:0] REG_POST_CNT  = 3'd4;
    localparam logic [2:0] REG_DATA      = 3'd5;
    localparam logic [2:0] REG_TSTAMP    = 3'd6;
    localparam logic [2:0] REG_TRIG_TS   = 3'd7;

    localparam int unsigned CTRL_ARM      = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned CTRL_FORCE    = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;
    localparam int unsigned STAT_WRAPPED  = 2;
    localparam int unsigned STAT_FILL_LSB = 16;

    // Replace the bytes of old_v selected by sel with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(logic [31:0] old_v, logic [31:0] new_v,
                                               logic [3:0] sel);
        return {sel[3] ? new_v[31:24] : old_v[31:24],
                sel[2] ? new_v[23:16] : old_v[23:16],
                sel[1] ? new_v[15:8]  : old_v[15:8],
                sel[0] ? new_v[7:0]   : old_v[7:0]};
    endfunction

endpackage

// File: rtl/hwdbg_trace_capture_if.sv
// Pipelined Wishbone slave port of the trace buffer (wb_ext_io window).
// Signal suffixes are from the slave's point of view.
interface hwdbg_trace_capture_if;
    logic [29:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/hwdbg_trace_ram.sv
// 1W1R synchronous sample RAM, 2^DEPTH_LOG2 x 32, registered read port.
module hwdbg_trace_ram #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);
    logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] rdata_q;

    // Write port and registered read port; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/hwdbg_trace_capture.sv
// Logic-analyser trace buffer on the wb_ext_io Wishbone port. Samples probe_i
// into a circular RAM, stops a programmable number of samples after the trigger,
// and is drained oldest-first through the DATA register.
// Optional feature macro: HWDBG_TRACE_TSTAMP_EN (cycle counter at offsets 6/7).
module hwdbg_trace_capture
    import hwdbg_trace_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic                        ext_clk,
    input  logic                        ext_rst_n,
    hwdbg_trace_capture_if.slave        wb,
    input  logic [31:0]                 probe_i,
    input  logic                        probe_vld_i,
    output logic                        irq_done_o
);
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    trace_state_e state_q, state_d;
    ptr_t         wr_ptr_q, wr_ptr_d, post_q, post_d, post_cfg_q, post_cfg_d;
    cnt_t         fill_q, fill_d, rd_cnt_q, rd_cnt_d, post_inc;
    logic         wrapped_q, wrapped_d, irq_en_q, irq_en_d, pop_q, pop_d, ack_q;
    logic [31:0]  trig_val_q, trig_val_d, trig_mask_q, trig_mask_d, dat_q, dat_d;
    logic [31:0]  post_merged, ram_rdata;
    logic         rd_req, wr_req, ctrl_wr, cmd_arm, cmd_abort, cmd_force, match, store;
    logic         unused_bits;
    logic [2:0]   adr;
    ptr_t         rd_addr;

    assign adr       = wb.wb_adr_i[2:0];
    assign rd_req    = wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_we_i;
    assign wr_req    = wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i;
    assign ctrl_wr   = wr_req && (adr == REG_CTRL) && wb.wb_sel_i[0];
    assign cmd_abort = ctrl_wr && wb.wb_dat_i[CTRL_ABORT];
    assign cmd_arm   = ctrl_wr && wb.wb_dat_i[CTRL_ARM] && !wb.wb_dat_i[CTRL_ABORT];
    assign cmd_force = ctrl_wr && wb.wb_dat_i[CTRL_FORCE] && !wb.wb_dat_i[CTRL_ABORT];
    assign match     = ((probe_i ^ trig_val_q) & trig_mask_q) == '0;
    assign post_inc  = {1'b0, post_q} + (DEPTH_LOG2 + 1)'(1);
    // Once wrapped, wr_ptr points at the oldest sample.
    assign rd_addr   = (wrapped_q ? wr_ptr_q : '0) + rd_cnt_q[DEPTH_LOG2-1:0];
    assign post_merged = byte_merge(32'(post_cfg_q), wb.wb_dat_i, wb.wb_sel_i);
    assign unused_bits = ^{wb.wb_adr_i[29:3], post_merged[31:DEPTH_LOG2]};

    hwdbg_trace_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk_i   (ext_clk),
        .we_i    (store),
        .waddr_i (wr_ptr_q),
        .wdata_i (probe_i),
        .re_i    (pop_d),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // Capture FSM: next state, sample storage, pointer/fill bookkeeping and DATA pops.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        wrapped_d = wrapped_q;
        post_d    = post_q;
        rd_cnt_d  = rd_cnt_q;
        store     = 1'b0;
        pop_d     = 1'b0;
        case (state_q)
            ST_ARMED: begin
                store = probe_vld_i;
                if (probe_vld_i && match) begin
                    state_d = (post_cfg_q == '0) ? ST_DONE : ST_TRIGGERED;
                end else if (cmd_force) begin
                    state_d = ST_TRIGGERED;
                end
            end
            ST_TRIGGERED: begin
                // >= also finishes a forced trigger with POST_CNT=0 without storing.
                if (post_q >= post_cfg_q) begin
                    state_d = ST_DONE;
                end else if (probe_vld_i) begin
                    store  = 1'b1;
                    post_d = post_inc[DEPTH_LOG2-1:0];
                    if (post_inc >= {1'b0, post_cfg_q}) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rd_req && (adr == REG_DATA) && (rd_cnt_q < fill_q)) begin
                    pop_d    = 1'b1;
                    rd_cnt_d = rd_cnt_q + (DEPTH_LOG2 + 1)'(1);
                end
            end
            default: ;
        endcase
        if (store) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (wr_ptr_q == '1) wrapped_d = 1'b1;
            if (!fill_q[DEPTH_LOG2]) fill_d = fill_q + (DEPTH_LOG2 + 1)'(1);
        end
        if (cmd_arm && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            fill_d    = '0;
            wrapped_d = 1'b0;
            post_d    = '0;
            rd_cnt_d  = '0;
        end
        if (cmd_abort) state_d = ST_IDLE;
    end

    // Configuration register writes with per-byte enables.
    always_comb begin
        irq_en_d    = irq_en_q;
        trig_val_d  = trig_val_q;
        trig_mask_d = trig_mask_q;
        post_cfg_d  = post_cfg_q;
        if (ctrl_wr) irq_en_d = wb.wb_dat_i[CTRL_IRQ_EN];
        if (wr_req) begin
            case (adr)
                REG_TRIG_VAL:  trig_val_d  = byte_merge(trig_val_q, wb.wb_dat_i, wb.wb_sel_i);
                REG_TRIG_MASK: trig_mask_d = byte_merge(trig_mask_q, wb.wb_dat_i, wb.wb_sel_i);
                REG_POST_CNT:  post_cfg_d  = post_merged[DEPTH_LOG2-1:0];
                default: ;
            endcase
        end
    end

`ifdef HWDBG_TRACE_TSTAMP_EN
    logic [31:0] tstamp_q, trig_ts_q;
    logic        trig_evt;
    assign trig_evt = (state_q == ST_ARMED) &&
                      (state_d == ST_TRIGGERED || state_d == ST_DONE);

    // Free-running cycle counter and its value captured at the trigger.
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            tstamp_q  <= '0;
            trig_ts_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
            if (trig_evt) trig_ts_q <= tstamp_q;
        end
    end
`endif

    // Register read mux; DATA pops are served straight from the RAM output.
    always_comb begin
        dat_d = '0;
        if (rd_req) begin
            case (adr)
                REG_CTRL:      dat_d[CTRL_IRQ_EN] = irq_en_q;
                REG_STATUS: begin
                    dat_d[1:0]                              = state_q;
                    dat_d[STAT_WRAPPED]                     = wrapped_q;
                    dat_d[STAT_FILL_LSB +: DEPTH_LOG2 + 1]  = fill_q;
                end
                REG_TRIG_VAL:  dat_d = trig_val_q;
                REG_TRIG_MASK: dat_d = trig_mask_q;
                REG_POST_CNT:  dat_d[DEPTH_LOG2-1:0] = post_cfg_q;
`ifdef HWDBG_TRACE_TSTAMP_EN
                REG_TSTAMP:    dat_d = tstamp_q;
                REG_TRIG_TS:   dat_d = trig_ts_q;
`endif
                default: ;
            endcase
        end
    end

    // State and register update.
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            wrapped_q   <= 1'b0;
            post_q      <= '0;
            rd_cnt_q    <= '0;
            post_cfg_q  <= '0;
            irq_en_q    <= 1'b0;
            trig_val_q  <= '0;
            trig_mask_q <= RESET_MASK;
            ack_q       <= 1'b0;
            pop_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            wrapped_q   <= wrapped_d;
            post_q      <= post_d;
            rd_cnt_q    <= rd_cnt_d;
            post_cfg_q  <= post_cfg_d;
            irq_en_q    <= irq_en_d;
            trig_val_q  <= trig_val_d;
            trig_mask_q <= trig_mask_d;
            ack_q       <= wb.wb_cyc_i && wb.wb_stb_i;
            pop_q       <= pop_d;
            dat_q       <= dat_d;
        end
    end

    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_dat_o   = pop_q ? ram_rdata : dat_q;
    assign wb.wb_stall_o = 1'b0;
    assign irq_done_o    = (state_q == ST_DONE) && irq_en_q;
endmodule

// File: tb/tb_hwdbg_trace_capture.sv
// Scoreboard bench for hwdbg_trace_capture: bus stimulus pushes expected read
// data, an ack monitor pops and compares. Expected capture results come from a
// batch model: first matching sample (or force point) plus POST_CNT samples.
module tb_hwdbg_trace_capture;
    localparam int DL2 = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] RMASK = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] probe = '0;
    logic        probe_vld = 1'b0;
    logic        irq;

    hwdbg_trace_capture_if bus ();

    hwdbg_trace_capture #(.DEPTH_LOG2(DL2), .RESET_MASK(RMASK)) dut (
        .ext_clk    (clk),
        .ext_rst_n  (rst_n),
        .wb         (bus),
        .probe_i    (probe),
        .probe_vld_i(probe_vld),
        .irq_done_o (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [31:0] exp;
        bit          chk;
        longint      t;
        string       name;
    } txn_t;
    txn_t sbq[$];

    always @(negedge clk) begin
        if (rst_n && bus.wb_ack_o) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: got ack with no request outstanding");
            end else begin
                txn_t tx;
                tx = sbq.pop_front();
                check({tx.name, "_latency"}, 32'($time - tx.t), 32'd10);
                if (tx.chk) check(tx.name, bus.wb_dat_o, tx.exp);
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_mode;      // 0: idle/frozen, 1: capture armed since last ARM
    logic [31:0] m_val, m_mask;
    int          m_post;
    bit          m_irq_en;
    int          m_fill_fix;
    bit          m_wrap_fix;
    logic [31:0] fed[$];      // every qualified sample seen since ARM
    int          force_idx;
    int          popped;

    function automatic void model_reset();
        m_mode = 0; m_val = '0; m_mask = RMASK; m_post = 0; m_irq_en = 0;
        m_fill_fix = 0; m_wrap_fix = 0; fed.delete(); force_idx = -1; popped = 0;
    endfunction

    function automatic int fill_of(int cnt);
        return (cnt > DEPTH) ? DEPTH : cnt;
    endfunction

    // st: 1 armed, 2 triggered, 3 done; cnt: number of samples kept.
    function automatic void eval(output int st, output int cnt);
        int t = -1;
        int lim = (force_idx >= 0) ? force_idx : fed.size();
        int total;
        for (int i = 0; i < lim; i++)
            if (t < 0 && ((fed[i] ^ m_val) & m_mask) == 32'h0) t = i;
        if (t >= 0) total = t + 1 + m_post;
        else if (force_idx >= 0) total = force_idx + m_post;
        else begin
            st = 1; cnt = fed.size();
            return;
        end
        if (total <= fed.size()) begin st = 3; cnt = total; end
        else begin st = 2; cnt = fed.size(); end
    endfunction

    function automatic int model_state();
        int st, cnt;
        if (m_mode == 0) return 0;
        eval(st, cnt);
        return st;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] r;
        int st, cnt;
        r = '0;
        if (m_mode == 0) begin
            r[31:16] = 16'(m_fill_fix);
            r[2] = m_wrap_fix;
        end else begin
            eval(st, cnt);
            r[1:0] = 2'(st);
            r[2] = (cnt >= DEPTH);
            r[31:16] = 16'(fill_of(cnt));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(int adr);
        int st, cnt, f;
        case (adr)
            0: return {28'h0, m_irq_en, 3'b000};
            1: return model_status();
            2: return m_val;
            3: return m_mask;
            4: return 32'(m_post);
            5: begin
                if (m_mode == 1) begin
                    eval(st, cnt);
                    f = fill_of(cnt);
                    if (st == 3 && popped < f) begin
                        popped++;
                        return fed[cnt - f + popped - 1];
                    end
                end
                return 32'h0;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic void model_write(int adr, logic [31:0] d, logic [3:0] s);
        int st, cnt;
        case (adr)
            0: if (s[0]) begin
                m_irq_en = d[3];
                st = model_state();
                if (d[1]) begin
                    if (m_mode == 1) begin
                        eval(st, cnt);
                        m_fill_fix = fill_of(cnt);
                        m_wrap_fix = (cnt >= DEPTH);
                    end
                    m_mode = 0;
                end else if (d[0] && (st == 0 || st == 3)) begin
                    m_mode = 1; fed.delete(); force_idx = -1; popped = 0;
                end else if (d[2] && st == 1) begin
                    force_idx = fed.size();
                end
            end
            2: m_val = merge(m_val, d, s);
            3: m_mask = merge(m_mask, d, s);
            4: m_post = int'(merge(32'(m_post), d, s)) & (DEPTH - 1);
            default: ;
        endcase
    endfunction

    function automatic logic exp_irq();
        return (model_state() == 3) && m_irq_en;
    endfunction

    // ---------------- bus / probe drivers (entered on a falling edge) ----------------
    task automatic bus_op(bit we, int adr, logic [31:0] dat, logic [3:0] sel,
                          logic [31:0] exp, bit chk, string name);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = {27'($urandom), 3'(adr)};
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        sbq.push_back('{exp, chk, $time, name});
        @(negedge clk);
    endtask

    task automatic bus_end();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic reg_write(int adr, logic [31:0] dat, logic [3:0] sel = 4'hF);
        model_write(adr, dat, sel);
        bus_op(1'b1, adr, dat, sel, 32'h0, 1'b0, "write");
        bus_end();
    endtask

    task automatic reg_read(int adr, string name, bit chk = 1'b1);
        logic [31:0] e;
        e = model_read(adr);
        bus_op(1'b0, adr, 32'h0, 4'hF, e, chk, name);
    endtask

    task automatic drain(int n, string name);
        for (int i = 0; i < n; i++) reg_read(5, name);
        bus_end();
    endtask

    task automatic feed(int n, bit counting, logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            probe     = counting ? base + 32'(i) : $urandom;
            probe_vld = counting ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (probe_vld && m_mode == 1) fed.push_back(probe);
            @(negedge clk);
        end
        probe_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic read_all(string tag);
        for (int a = 0; a < 8; a++)
`ifdef HWDBG_TRACE_TSTAMP_EN
            reg_read(a, $sformatf("%s_off%0d", tag, a), a < 6);
`else
            reg_read(a, $sformatf("%s_off%0d", tag, a));
`endif
        bus_end();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rst_dat", bus.wb_dat_o, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_all("reset");

        // byte enables, read-only offsets, CTRL commands gated by sel[0]
        reg_write(2, 32'hFFFF_FFFF, 4'b0101);
        reg_write(1, 32'hFFFF_FFFF);
        reg_write(0, 32'h0000_0001, 4'b1110);
        reg_read(2, "trigval_bytes"); reg_read(1, "status_ro"); bus_end();

        // counting probe, exact match on 0x55, three post samples
        reg_write(3, 32'hFFFF_FFFF);
        reg_write(2, 32'h0000_0055);
        reg_write(4, 32'd3);
        reg_write(0, 32'h9);
        check("irq_armed", {31'h0, irq}, {31'h0, exp_irq()});
        feed(12, 1'b1, 32'h50);
        check("irq_done", {31'h0, irq}, {31'h0, exp_irq()});
        reg_read(1, "status_done"); bus_end();
        drain(10, "pop_count");
        reg_write(0, 32'h9);
        check("irq_rearm", {31'h0, irq}, {31'h0, exp_irq()});
        reg_write(0, 32'h2);
        reg_write(0, 32'h3);
        reg_read(1, "status_arm_abort"); bus_end();

        // wrap-around with a forced trigger
        reg_write(2, 32'hDEAD_0000);
        reg_write(4, 32'd2);
        reg_write(0, 32'h9);
        feed(40, 1'b1, 32'h0);
        reg_write(0, 32'hC);
        feed(5, 1'b1, 32'd100);
        reg_read(1, "status_wrap"); bus_end();
        drain(17, "pop_wrap");

        // abort while triggered
        reg_write(0, 32'h2);
        reg_write(3, 32'h0000_000F);
        reg_write(2, 32'h0000_0007);
        reg_write(4, 32'd15);
        reg_write(0, 32'h9);
        feed(10, 1'b1, 32'h0);
        reg_read(1, "status_trig"); bus_end();
        reg_write(0, 32'hA);
        check("irq_abort", {31'h0, irq}, {31'h0, exp_irq()});
        reg_read(1, "status_aborted"); drain(1, "pop_idle");

        // randomized captures
        for (int it = 0; it < 8; it++) begin
            logic [31:0] ctl;
            reg_write(3, $urandom & 32'h0000_0303);
            reg_write(2, $urandom);
            reg_write(4, 32'($urandom_range(0, 15)));
            ctl = {28'h0, 1'($urandom), 3'b001};
            reg_write(0, ctl);
            feed($urandom_range(4, 30), 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) reg_write(0, ctl | 32'h4);
            feed($urandom_range(4, 30), 1'b0, 32'h0);
            check("irq_rand", {31'h0, irq}, {31'h0, exp_irq()});
            reg_read(1, "status_rand"); bus_end();
            drain(DEPTH + 1, "pop_rand");
            reg_write(0, 32'h2);
            reg_read(1, "status_rand_idle"); bus_end();
        end

        // asynchronous reset in the middle of a triggered capture
        reg_write(3, 32'h0000_000F);
        reg_write(2, 32'h0000_0003);
        reg_write(4, 32'd15);
        reg_write(0, 32'h9);
        feed(6, 1'b1, 32'h0);
        reg_read(1, "status_pre_rst");
        reg_read(3, "mask_pre_rst");
        bus_end();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("async_rst_dat", bus.wb_dat_o, 32'h0);
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all("post_rst");

        repeat (3) @(negedge clk);
        check("acks_outstanding", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
